// File: rtl/stack_pkg.sv
// Shared encodings and per-command tables for the stack operation sequencer:
// register-stack operations, command opcodes, operand needs and step decode.
package stack_pkg;

   localparam int STACK_SIZE_DEF = 32;

   typedef enum logic [2:0] {
      SOP_NONE   = 3'd0,
      SOP_PUSH   = 3'd1,
      SOP_POPREP = 3'd2,
      SOP_POP    = 3'd3,
      SOP_POP2   = 3'd4,
      SOP_SWAP   = 3'd5
   } stack_op_e;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_PUSHI = 4'd1,
      OP_DUP   = 4'd2,
      OP_DROP  = 4'd3,
      OP_SWAP  = 4'd4,
      OP_ADD   = 4'd5,
      OP_SUB   = 4'd6,
      OP_OVER  = 4'd7,
      OP_DROP2 = 4'd8,
      OP_NIP   = 4'd9,
      OP_ADDI  = 4'd10,
      OP_DUP2  = 4'd11
   } cmd_op_e;

   // Source of the write word for a step; W_HOLD leaves w untouched.
   typedef enum logic [2:0] {W_HOLD, W_IMM, W_A, W_B, W_ALU} wsel_e;

   typedef struct packed {
      stack_op_e sop;
      wsel_e     wsel;
   } step_t;

   function automatic logic [1:0] min_operands(input logic [3:0] op);
      case (op)
         OP_DUP, OP_DROP, OP_ADDI:                         min_operands = 2'd1;
         OP_SWAP, OP_ADD, OP_SUB, OP_OVER, OP_DROP2,
         OP_NIP, OP_DUP2:                                  min_operands = 2'd2;
         default:                                          min_operands = 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] push_count(input logic [3:0] op);
      case (op)
         OP_PUSHI, OP_DUP, OP_OVER: push_count = 2'd1;
         OP_DUP2:                   push_count = 2'd2;
         default:                   push_count = 2'd0;
      endcase
   endfunction

   function automatic logic is_two_step(input logic [3:0] op);
      return (op == OP_NIP) || (op == OP_ADDI) || (op == OP_DUP2);
   endfunction

   function automatic step_t first_step(input logic [3:0] op);
      case (op)
         OP_PUSHI: first_step = '{sop: SOP_PUSH,   wsel: W_IMM};
         OP_DUP:   first_step = '{sop: SOP_PUSH,   wsel: W_A};
         OP_DROP:  first_step = '{sop: SOP_POP,    wsel: W_HOLD};
         OP_SWAP:  first_step = '{sop: SOP_SWAP,   wsel: W_HOLD};
         OP_ADD:   first_step = '{sop: SOP_POPREP, wsel: W_ALU};
         OP_SUB:   first_step = '{sop: SOP_POPREP, wsel: W_ALU};
         OP_OVER:  first_step = '{sop: SOP_PUSH,   wsel: W_B};
         OP_DROP2: first_step = '{sop: SOP_POP2,   wsel: W_HOLD};
         OP_NIP:   first_step = '{sop: SOP_SWAP,   wsel: W_HOLD};
         OP_ADDI:  first_step = '{sop: SOP_PUSH,   wsel: W_IMM};
         OP_DUP2:  first_step = '{sop: SOP_PUSH,   wsel: W_B};
         default:  first_step = '{sop: SOP_NONE,   wsel: W_HOLD};
      endcase
   endfunction

   function automatic step_t second_step(input logic [3:0] op);
      case (op)
         OP_NIP:  second_step = '{sop: SOP_POP,    wsel: W_HOLD};
         OP_ADDI: second_step = '{sop: SOP_POPREP, wsel: W_ALU};
         OP_DUP2: second_step = '{sop: SOP_PUSH,   wsel: W_B};
         default: second_step = '{sop: SOP_NONE,   wsel: W_HOLD};
      endcase
   endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational 16-bit adder/subtractor producing b+a or b-a; carry and
// borrow are discarded.
module stack_alu (
   input  logic        i_sub,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_y
);

   assign o_y = i_sub ? (i_b - i_a) : (i_b + i_a);

endmodule

// File: rtl/stack_op_sequencer.sv
// Turns stack-machine commands into one or two register-stack operations,
// tracking live depth and rejecting commands that would under/overflow.
module stack_op_sequencer
   import stack_pkg::*;
#(
   parameter int STACK_SIZE = STACK_SIZE_DEF
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_imm,
   input  logic [15:0] stack_a,
   input  logic [15:0] stack_b,
   output logic [2:0]  stackOP,
   output logic [15:0] w,
   output logic [5:0]  depth,
   output logic        err
);

   typedef enum logic {ST_IDLE, ST_STEP2} state_e;

   state_e      r_state;
   logic [3:0]  r_op;
   logic        r_ready;
   stack_op_e   r_stack_op;
   logic [15:0] r_w;
   logic [5:0]  r_depth;
   logic        r_err;

   logic        w_accept;
   logic        w_legal;
   step_t       w_step;
   logic [15:0] w_alu_y;
   logic        w_alu_sub;
   logic [15:0] w_wdata;
   logic [5:0]  w_depth_next;

   stack_alu u_alu (
      .i_sub (w_alu_sub),
      .i_a   (stack_a),
      .i_b   (stack_b),
      .o_y   (w_alu_y)
   );

   // STEP2 only ever adds (ADDI), so subtraction is tied to an accepted SUB.
   assign w_alu_sub = (r_state == ST_IDLE) && (cmd_op == OP_SUB);
   assign w_accept  = cmd_valid && r_ready && (r_state == ST_IDLE);
   assign w_legal   = (r_depth >= 6'(min_operands(cmd_op))) &&
                      (({1'b0, r_depth} + 7'(push_count(cmd_op))) <= 7'(STACK_SIZE));

   // NOTE: every signal gets a default first so no path leaves one unassigned
   // and infers a latch.
   always_comb begin
      w_step       = '{sop: SOP_NONE, wsel: W_HOLD};
      w_wdata      = r_w;
      w_depth_next = r_depth;
      if (r_state == ST_STEP2)
         w_step = second_step(r_op);
      else if (w_accept && w_legal)
         w_step = first_step(cmd_op);

      case (w_step.wsel)
         W_IMM:   w_wdata = cmd_imm;
         W_A:     w_wdata = stack_a;
         W_B:     w_wdata = stack_b;
         W_ALU:   w_wdata = w_alu_y;
         default: w_wdata = r_w;
      endcase

      case (w_step.sop)
         SOP_PUSH:            w_depth_next = r_depth + 6'd1;
         SOP_POPREP, SOP_POP: w_depth_next = r_depth - 6'd1;
         SOP_POP2:            w_depth_next = r_depth - 6'd2;
         default:             w_depth_next = r_depth;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= ST_IDLE;
         r_op       <= OP_NOP;
         r_ready    <= 1'b0;
         r_stack_op <= SOP_NONE;
         r_w        <= '0;
         r_depth    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_stack_op <= w_step.sop;
         r_w        <= w_wdata;
         r_depth    <= w_depth_next;
         r_err      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  if (!w_legal) begin
                     r_err <= 1'b1;
                  end else if (is_two_step(cmd_op)) begin
                     r_state <= ST_STEP2;
                     r_op    <= cmd_op;
                     r_ready <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign stackOP   = r_stack_op;
   assign w         = r_w;
   assign depth     = r_depth;
   assign err       = r_err;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural register stack
// that applies stackOP/w on the falling edge.
module tb_stack_op_sequencer;
   import stack_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = 4'd0;
   logic [15:0] cmd_imm = 16'd0;
   logic [15:0] stack_a;
   logic [15:0] stack_b;
   logic [2:0]  stackOP;
   logic [15:0] w;
   logic [5:0]  depth;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [0:39];
   int          cnt = 0;

   stack_op_sequencer #(.STACK_SIZE(32)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_imm   (cmd_imm),
      .stack_a   (stack_a),
      .stack_b   (stack_b),
      .stackOP   (stackOP),
      .w         (w),
      .depth     (depth),
      .err       (err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt <= 0;
      end else begin
         case (stackOP)
            3'd1: if (cnt < 40) begin mem[cnt] <= w; cnt <= cnt + 1; end
            3'd2: if (cnt >= 2) begin mem[cnt-2] <= w; cnt <= cnt - 1; end
            3'd3: if (cnt >= 1) cnt <= cnt - 1;
            3'd4: if (cnt >= 2) cnt <= cnt - 2;
            3'd5: if (cnt >= 2) begin mem[cnt-1] <= mem[cnt-2]; mem[cnt-2] <= mem[cnt-1]; end
            default: ;
         endcase
      end
   end

   assign stack_a = (cnt >= 1) ? mem[cnt-1] : 16'd0;
   assign stack_b = (cnt >= 2) ? mem[cnt-2] : 16'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Offers one command once cmd_ready is seen, returning 1 time unit after
   // the accepting edge.
   task automatic send(input logic [3:0] op, input logic [15:0] imm);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      if (n >= 8) check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_imm   = imm;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_sop",   {29'd0, stackOP},   32'd0);
      check("rst_w",     {16'd0, w},         32'd0);
      check("rst_depth", {26'd0, depth},     32'd0);
      check("rst_err",   {31'd0, err},       32'd0);
      #10;
      RESET_N = 1'b1;
      tick();
      check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // PUSHI 5, PUSHI 3, ADD
      send(OP_PUSHI, 16'd5);
      check("p5_sop",   {29'd0, stackOP}, 32'd1);
      check("p5_w",     {16'd0, w},       32'd5);
      check("p5_depth", {26'd0, depth},   32'd1);
      send(OP_PUSHI, 16'd3);
      check("p3_sop",   {29'd0, stackOP}, 32'd1);
      check("p3_depth", {26'd0, depth},   32'd2);
      send(OP_ADD, 16'd0);
      check("add_sop",   {29'd0, stackOP}, 32'd2);
      check("add_w",     {16'd0, w},       32'd8);
      check("add_depth", {26'd0, depth},   32'd1);
      tick();
      check("add_top",    {16'd0, stack_a}, 32'd8);
      check("idle_sop",   {29'd0, stackOP}, 32'd0);
      check("idle_whold", {16'd0, w},       32'd8);

      // SUB both ways: [a=3,b=5] -> 2, [a=5,b=3] -> 0xFFFE
      send(OP_PUSHI, 16'd5);
      send(OP_PUSHI, 16'd3);
      send(OP_SUB, 16'd0);
      check("sub_pos_w",     {16'd0, w},     32'h0002);
      check("sub_pos_depth", {26'd0, depth}, 32'd2);
      send(OP_DROP, 16'd0);
      send(OP_PUSHI, 16'd3);
      send(OP_PUSHI, 16'd5);
      send(OP_SUB, 16'd0);
      check("sub_neg_w",     {16'd0, w},     32'hFFFE);
      check("sub_neg_depth", {26'd0, depth}, 32'd2);

      // Underflow: SWAP at depth 1, DROP at depth 0
      send(OP_DROP, 16'd0);
      check("drop_sop", {29'd0, stackOP}, 32'd3);
      check("drop_depth", {26'd0, depth}, 32'd1);
      send(OP_SWAP, 16'd0);
      check("swap_uf_err",   {31'd0, err},     32'd1);
      check("swap_uf_sop",   {29'd0, stackOP}, 32'd0);
      check("swap_uf_depth", {26'd0, depth},   32'd1);
      tick();
      check("err_pulse_end", {31'd0, err}, 32'd0);
      send(OP_DROP, 16'd0);
      check("drop_to0", {26'd0, depth}, 32'd0);
      send(OP_DROP, 16'd0);
      check("drop_uf_err",   {31'd0, err},   32'd1);
      check("drop_uf_depth", {26'd0, depth}, 32'd0);

      // DUP2 on [a=1,b=2] -> stack 1,2,1,2
      send(OP_PUSHI, 16'd2);
      send(OP_PUSHI, 16'd1);
      send(OP_DUP2, 16'd0);
      check("dup2_s1_sop",   {29'd0, stackOP},   32'd1);
      check("dup2_s1_w",     {16'd0, w},         32'd2);
      check("dup2_ready_lo", {31'd0, cmd_ready}, 32'd0);
      check("dup2_s1_depth", {26'd0, depth},     32'd3);
      tick();
      check("dup2_s2_sop",   {29'd0, stackOP},   32'd1);
      check("dup2_s2_w",     {16'd0, w},         32'd1);
      check("dup2_ready_hi", {31'd0, cmd_ready}, 32'd1);
      check("dup2_depth",    {26'd0, depth},     32'd4);
      tick();
      check("dup2_stack", {mem[3], mem[2]}, {16'd1, 16'd2});
      check("dup2_low",   {mem[1], mem[0]}, {16'd1, 16'd2});

      // ADDI 4 on [a=7]
      send(OP_PUSHI, 16'd7);
      send(OP_ADDI, 16'd4);
      check("addi_s1_sop", {29'd0, stackOP}, 32'd1);
      check("addi_s1_w",   {16'd0, w},       32'd4);
      tick();
      check("addi_s2_sop", {29'd0, stackOP}, 32'd2);
      check("addi_s2_w",   {16'd0, w},       32'd11);
      check("addi_depth",  {26'd0, depth},   32'd5);
      tick();
      check("addi_top", {16'd0, stack_a}, 32'd11);

      // NIP on [11,1,2,1,2] -> [11,2,1,2]
      send(OP_NIP, 16'd0);
      check("nip_s1_sop", {29'd0, stackOP}, 32'd5);
      tick();
      check("nip_s2_sop", {29'd0, stackOP}, 32'd3);
      check("nip_depth",  {26'd0, depth},   32'd4);
      tick();
      check("nip_top", {stack_a, stack_b}, {16'd11, 16'd2});

      // NOP and reserved opcode: consumed silently
      send(OP_NOP, 16'd0);
      check("nop", {26'd0, depth, err, stackOP}, {26'd4, 1'b0, 3'd0});
      send(4'd13, 16'd0);
      check("op13", {26'd0, depth, err, stackOP}, {26'd4, 1'b0, 3'd0});

      // OVER then DROP2
      send(OP_OVER, 16'd0);
      check("over_w", {16'd0, w}, 32'd2);
      check("over_depth", {26'd0, depth}, 32'd5);
      send(OP_DROP2, 16'd0);
      check("drop2_sop",   {29'd0, stackOP}, 32'd4);
      check("drop2_depth", {26'd0, depth},   32'd3);

      // Overflow boundaries
      for (int i = 0; i < 28; i++) send(OP_PUSHI, 16'(i + 100));
      check("fill_depth", {26'd0, depth}, 32'd31);
      send(OP_DUP2, 16'd0);
      check("dup2_of_err",   {31'd0, err},     32'd1);
      check("dup2_of_sop",   {29'd0, stackOP}, 32'd0);
      check("dup2_of_depth", {26'd0, depth},   32'd31);
      send(OP_DUP, 16'd0);
      check("dup31_err",   {31'd0, err},     32'd0);
      check("dup31_sop",   {29'd0, stackOP}, 32'd1);
      check("dup31_depth", {26'd0, depth},   32'd32);
      send(OP_PUSHI, 16'd1);
      check("push32_err",   {31'd0, err},   32'd1);
      check("push32_depth", {26'd0, depth}, 32'd32);

      // Reset during STEP2 of NIP
      send(OP_NIP, 16'd0);
      check("nip_rst_s1", {29'd0, stackOP}, 32'd5);
      RESET_N = 1'b0;
      #1;
      check("rst2_sop",   {29'd0, stackOP},   32'd0);
      check("rst2_depth", {26'd0, depth},     32'd0);
      check("rst2_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      tick();
      check("rst2_ready_hi", {31'd0, cmd_ready}, 32'd1);
      check("rst2_no_step",  {29'd0, stackOP},   32'd0);
      check("rst2_depth_hold", {26'd0, depth},   32'd0);
      send(OP_PUSHI, 16'd9);
      check("post_rst_push", {26'd0, depth}, 32'd1);
      check("post_rst_w",    {16'd0, w},     32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stack_op_sequencer.md
STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 The block SHALL have one parameter: STACK_SIZE, 32, register-stack depth in words.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 CLK  in  1  system clock; sequencer state updates on the posedge; the register stack consumes stackOP/w on the negedge.
REQ-004 RESET_N  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge.
REQ-007 cmd_op  in  4  command opcode.
REQ-008 cmd_imm  in  16  immediate for PUSHI/ADDI.
REQ-009 stack_a  in  16  stack top, returned from the register stack.
REQ-010 stack_b  in  16  stack second, returned from the register stack.
REQ-011 stackOP  out  3  registered stack operation: 0 none, 1 push, 2 pop-and-replace, 3 pop, 4 pop 2, 5 swap.
REQ-012 w  out  16  registered write word.
REQ-013 depth  out  6  number of live stack entries (0..STACK_SIZE).
REQ-014 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-015 Commands SHALL be: 0 NOP; 1 PUSHI (push imm); 2 DUP (push a); 3 DROP (pop); 4 SWAP; 5 ADD (pop-replace w=b+a); 6 SUB (pop-replace w=b-a); 7 OVER (push b); 8 DROP2 (pop 2); 9 NIP (swap, then pop); 10 ADDI (push imm, then pop-replace w=b+a); 11 DUP2 (OVER, then OVER); 12-15 are treated as NOP.
REQ-016 Arithmetic SHALL be 16-bit modulo; carry and borrow are discarded.
REQ-017 FSM states SHALL be IDLE and STEP2; cmd_ready=1 only in IDLE.
REQ-018 On accept in IDLE, stackOP/w SHALL load the first step at that posedge, with w computed from stack_a/stack_b/cmd_imm sampled at that edge.
REQ-019 Single-step commands SHALL remain in IDLE; two-step commands SHALL go to STEP2, which issues the second step at the next posedge using the updated stack_a/stack_b, then returns to IDLE.
REQ-020 When no step is issued in a cycle, stackOP SHALL be 0, and w SHALL hold its previous value.
REQ-021 Back-to-back accepts SHALL be legal; throughput is 1 command/cycle for single-step and 1 per 2 cycles for two-step.
REQ-022 The result SHALL be visible on stack_a at the posedge after the final step is issued.
REQ-023 depth SHALL update at the same posedge a step is issued: push +1, pop-replace -1, pop -1, pop 2 -2, swap 0.
REQ-024 Underflow check SHALL be made at accept against the net requirement: DUP/DROP need depth >= 1; SWAP/ADD/SUB/OVER/DROP2/NIP need >= 2; ADDI needs >= 1; DUP2 needs >= 2.
REQ-025 Overflow check SHALL be made at accept: PUSHI/DUP/OVER need depth <= STACK_SIZE-1; DUP2 needs <= STACK_SIZE-2.
REQ-026 A command failing REQ-024/REQ-025 SHALL be consumed: err=1 for one cycle, no stackOP issued, depth unchanged.
REQ-027 NOP SHALL be consumed with no stackOP and no err.

Reset
REQ-028 On RESET_N low, the block SHALL set state=IDLE, stackOP=0, w=0, depth=0, err=0, cmd_ready=0, asynchronously.
REQ-029 After RESET_N deasserts, cmd_ready SHALL go to 1 at the first posedge.
REQ-030 Reset during STEP2 SHALL abandon the second step; stack contents beyond depth are don't-care.

Structure
REQ-031 A shared package stack_pkg SHALL hold the stackOP encodings, the command opcodes, STACK_SIZE, and per-command operand/push-count tables.
REQ-032 The block SHALL use one combinational sub-module, stack_alu (ADD/SUB selection), instantiated once.

Verification
REQ-033 After reset, PUSHI 5, PUSHI 3, ADD -> stackOP sequence 1,1,2; stack_a=8; depth=1.
REQ-034 With stack [a=3,b=5], SUB -> w=2; with [a=5,b=3], SUB -> w=0xFFFE.
REQ-035 With depth=1, SWAP -> err pulses, no stackOP, depth stays 1; with depth=0, DROP -> err.
REQ-036 With depth=32, PUSHI -> err; with depth=31, DUP2 -> err; with depth=31, DUP -> depth=32, no err.
REQ-037 With stack [a=1,b=2], DUP2 -> cmd_ready low for 1 cycle, stackOP 7-free sequence 1,1, stack top 1,2,1,2; with [a=7], ADDI 4 -> stackOP 1 then 2, stack_a=11, depth unchanged.
REQ-038 Assert RESET_N during STEP2 of NIP -> stackOP=0 immediately; depth=0; cmd_ready=1 one posedge after release.
